cisc_seq_ctrl: RTL and testbench
================================

Name: cisc_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the 8-bit CISC ALU datapath. It owns the 16-entry register file and accepts one instruction at a time over a valid/ready handshake. It steps the instruction through operand read, execute and writeback, then presents the result over a second valid/ready handshake. It sits between the instruction source (test driver or fetch unit) and the ALU/register-file datapath.

Parameters:
DATA_W, 8, datapath and register width in bits
NREGS, 16, number of registers; register index width is log2(NREGS)=4

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction presented
in_ready  output  1  sequencer can accept an instruction; high only in IDLE
in_opcode  input  8  operation code
in_rd  input  4  destination register index
in_rs1  input  4  source register 1 index
in_rs2  input  4  source register 2 index
in_imm  input  8  immediate, used by LDI only
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_result  output  8  ALU result of the completed instruction
out_rd  output  4  destination index of the completed instruction
out_illegal  output  1  completed instruction had an undefined opcode
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all 16 registers=0; out_valid=0, out_result=0, out_rd=0, out_illegal=0, busy=0, in_ready=1 once rst_n=1. Reset mid-instruction aborts it with no writeback.
- States: IDLE -> RD -> EX -> WB -> RESP -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready at edge E0, latch opcode/rd/rs1/rs2/imm and go to RD. Inputs are ignored at all other times.
- RD (edge E1): latch opA=reg[rs1], opB=reg[rs2]; go to EX.
- EX (edge E2): latch alu_r; go to WB.
  - 00 ADD: A+B.
  - 01 SUB: A-B.
  - 02 AND: A&B.
  - 03 OR: A|B.
  - 04 XOR: A^B.
  - 05 NOT: ~A, rs2 ignored.
  - 06 LDI: imm.
  - 07 MOV: A.
  - Other opcodes: 0, illegal=1.
  - All arithmetic is mod 2^DATA_W; carry and borrow are discarded.
- WB (edge E3): if not illegal, reg[rd]<=alu_r. out_result<=alu_r, out_rd<=rd, out_illegal<=illegal, out_valid<=1. Go to RESP.
- RESP: out_valid and outputs hold stable until out_valid&&out_ready at an edge. At that edge out_valid<=0 and the state returns to IDLE. out_result, out_rd and out_illegal keep their last value.
- Latency: out_valid rises 3 cycles after the accept edge. Minimum issue interval is 5 cycles with out_ready tied high.
- Hazards: writeback completes before the next accept, so a dependent instruction always reads the updated value. rd==rs1==rs2 is legal.
- in_valid high outside IDLE: no effect; the driver must hold it until in_ready is seen.

Optional Feature:
Macro CISC_SEQ_FLAGS_EN.
- Defined: adds outputs out_zero (1 bit) and out_carry (1 bit), both registered in WB alongside out_result and reset to 0.
  - out_zero = (alu_r==0), and is 0 for illegal opcodes.
  - out_carry = bit DATA_W of A+B for ADD, or (A<B) borrow for SUB; 0 for all other opcodes.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then LDI r1,imm=0x2A -> out_valid 3 cycles after accept, out_result=0x2A, out_rd=1; a following MOV r2,r1 returns 0x2A.
- LDI r1=0xF0, LDI r2=0x20, ADD r3,r1,r2 -> out_result=0x10 (wrap); with FLAGS_EN, out_carry=1 and out_zero=0.
- LDI r4=0x05, SUB r5,r4,r4 -> 0x00 (zero=1 with FLAGS_EN); NOT r6,r4 -> 0xFA; XOR r7,r4,r6 -> 0xFF.
- Opcode 0x3C, rd=8 -> out_illegal=1, out_result=0; a following MOV r9,r8 returns 0x00, proving r8 was not written.
- Hold out_ready=0 for 6 cycles in RESP -> out_valid, out_result and out_rd stay stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> back to IDLE next cycle.
- Assert rst_n=0 during EX of LDI r1=0x77 -> out_valid=0, busy=0, and a later MOV r2,r1 returns 0x00.

Source files
------------

// File: rtl/cisc_seq_ctrl.sv
// cisc_seq_ctrl: multi-cycle sequencer for the 8-bit CISC ALU datapath.
// It owns the register file and steps each accepted instruction through
// IDLE -> RD -> EX -> WB -> RESP, with valid/ready handshakes on both sides.
// Optional flag outputs (out_zero, out_carry) are built when the macro
// CISC_SEQ_FLAGS_EN is defined.
module cisc_seq_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 16,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [IDX_W-1:0]  in_rd,
  input  logic [IDX_W-1:0]  in_rs1,
  input  logic [IDX_W-1:0]  in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [IDX_W-1:0]  out_rd,
  output logic              out_illegal,
  output logic              busy
`ifdef CISC_SEQ_FLAGS_EN
  ,
  output logic              out_zero,
  output logic              out_carry
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EX   = 3'd2,
    WB   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h05;
  localparam logic [7:0] OP_LDI = 8'h06;
  localparam logic [7:0] OP_MOV = 8'h07;

  state_t state_reg, state_next;

  logic [7:0]        opc_reg;
  logic [IDX_W-1:0]  rd_reg, rs1_reg, rs2_reg;
  logic [DATA_W-1:0] imm_reg, opa_reg, opb_reg, alu_reg;
  logic              ill_reg;
  logic [DATA_W-1:0] alu_next;
  logic              ill_next;
  logic              wb_en;
  logic [DATA_W-1:0] regs [NREGS];

`ifdef CISC_SEQ_FLAGS_EN
  logic carry_reg, carry_next;
`endif

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign wb_en    = (state_reg == WB) && !ill_reg;

  // State register; an asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: fixed walk through the pipeline steps, waiting only
  // for an incoming instruction in IDLE and for the consumer in RESP.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RD;
      RD:      state_next = EX;
      EX:      state_next = WB;
      WB:      state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU: combinational on the latched operands, captured at the end of EX.
  always_comb begin
    alu_next = '0;
    ill_next = 1'b0;
    case (opc_reg)
      OP_ADD:  alu_next = opa_reg + opb_reg;
      OP_SUB:  alu_next = opa_reg - opb_reg;
      OP_AND:  alu_next = opa_reg & opb_reg;
      OP_OR:   alu_next = opa_reg | opb_reg;
      OP_XOR:  alu_next = opa_reg ^ opb_reg;
      OP_NOT:  alu_next = ~opa_reg;
      OP_LDI:  alu_next = imm_reg;
      OP_MOV:  alu_next = opa_reg;
      default: ill_next = 1'b1;
    endcase
  end

`ifdef CISC_SEQ_FLAGS_EN
  // Carry out of an add shows up as a wrapped sum smaller than an operand;
  // borrow of a subtract is simply A < B.
  always_comb begin
    carry_next = 1'b0;
    if (opc_reg == OP_ADD) carry_next = (DATA_W'(opa_reg + opb_reg) < opa_reg);
    else if (opc_reg == OP_SUB) carry_next = (opa_reg < opb_reg);
  end
`endif

  // Datapath registers: instruction latch, operand fetch, ALU capture and
  // the result holding registers presented to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_reg     <= '0;
      rd_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      imm_reg     <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      alu_reg     <= '0;
      ill_reg     <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            opc_reg <= in_opcode;
            rd_reg  <= in_rd;
            rs1_reg <= in_rs1;
            rs2_reg <= in_rs2;
            imm_reg <= in_imm;
          end
        end
        RD: begin
          opa_reg <= regs[rs1_reg];
          opb_reg <= regs[rs2_reg];
        end
        EX: begin
          alu_reg <= alu_next;
          ill_reg <= ill_next;
        end
        WB: begin
          out_result  <= alu_reg;
          out_rd      <= rd_reg;
          out_illegal <= ill_reg;
          out_valid   <= 1'b1;
        end
        RESP: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CISC_SEQ_FLAGS_EN
  // Flags travel with the result: carry captured in EX, both published in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
    end else begin
      if (state_reg == EX) carry_reg <= carry_next;
      if (state_reg == WB) begin
        out_zero  <= !ill_reg && (alu_reg == '0);
        out_carry <= carry_reg;
      end
    end
  end
`endif

  // Register file: one flop bank per entry so reset can clear every entry;
  // writes happen only in WB for legal opcodes.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q;
      // Single register entry with its own write decode.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (wb_en && (rd_reg == IDX_W'(gi))) begin
          q <= alu_reg;
        end
      end
      assign regs[gi] = q;
    end
  endgenerate

endmodule

// File: tb/tb_cisc_seq_ctrl.sv
// Self-checking bench for cisc_seq_ctrl: directed vector table, handshake
// and reset corner cases, then randomized instructions against a model.
module tb_cisc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_opcode = '0;
  logic [3:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [7:0] in_imm = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic [3:0] out_rd;
  logic       out_illegal;
  logic       busy;
`ifdef CISC_SEQ_FLAGS_EN
  logic       out_zero, out_carry;
`endif

  int total_checks = 0;
  int pass_checks  = 0;
  int ref_regs [16];

  cisc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal),
    .busy(busy)
`ifdef CISC_SEQ_FLAGS_EN
    , .out_zero(out_zero), .out_carry(out_carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic [7:0] exp_res;
    logic       exp_ill;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) pass_checks++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference semantics in plain integer arithmetic: {carry, zero, ill, res}.
  function automatic logic [10:0] model(input int op, input int a, input int b, input int imm);
    int r; int c; int ill;
    r = 0; c = 0; ill = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = imm;
      7: r = a;
      default: ill = 1;
    endcase
    return {c[0], (ill == 0 && r == 0), ill[0], r[7:0]};
  endfunction

  // Issue one instruction with out_ready high and check the full response.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [7:0] imm,
                           input logic [7:0] exp_res, input logic exp_ill, input string tag);
    int lat;
    logic [10:0] m;
    m = model(op, ref_regs[rs1], ref_regs[rs2], imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 3);
    chk({tag, " result"}, out_result, exp_res);
    chk({tag, " rd"}, out_rd, rd);
    chk({tag, " illegal"}, out_illegal, exp_ill);
    chk({tag, " in_ready_resp"}, in_ready, 0);
`ifdef CISC_SEQ_FLAGS_EN
    chk({tag, " zero"}, out_zero, m[9]);
    chk({tag, " carry"}, out_carry, m[10]);
`endif
    @(posedge clk); #1;
    chk({tag, " valid_drop"}, out_valid, 0);
    chk({tag, " idle_ready"}, in_ready, 1);
    $display("instr %s op=%02h rd=%0d rs1=%0d rs2=%0d imm=%02h -> res=%02h ill=%0d model=%02h",
             tag, op, rd, rs1, rs2, imm, out_result, out_illegal, m[7:0]);
    if (!exp_ill) ref_regs[rd] = exp_res;
  endtask

  // Issue using the model for the expected result.
  task automatic run_model(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [7:0] imm, input string tag);
    logic [10:0] m;
    m = model(op, ref_regs[rs1], ref_regs[rs2], imm);
    run_instr(op, rd, rs1, rs2, imm, m[7:0], m[8], tag);
  endtask

  initial begin
    vec_t vecs [13];
    int lat;
    vecs[0]  = '{8'h06, 4'd1,  4'd0, 4'd0, 8'h2A, 8'h2A, 1'b0};
    vecs[1]  = '{8'h07, 4'd2,  4'd1, 4'd0, 8'h00, 8'h2A, 1'b0};
    vecs[2]  = '{8'h06, 4'd1,  4'd0, 4'd0, 8'hF0, 8'hF0, 1'b0};
    vecs[3]  = '{8'h06, 4'd2,  4'd0, 4'd0, 8'h20, 8'h20, 1'b0};
    vecs[4]  = '{8'h00, 4'd3,  4'd1, 4'd2, 8'h00, 8'h10, 1'b0};
    vecs[5]  = '{8'h06, 4'd4,  4'd0, 4'd0, 8'h05, 8'h05, 1'b0};
    vecs[6]  = '{8'h01, 4'd5,  4'd4, 4'd4, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{8'h05, 4'd6,  4'd4, 4'd9, 8'h00, 8'hFA, 1'b0};
    vecs[8]  = '{8'h04, 4'd7,  4'd4, 4'd6, 8'h00, 8'hFF, 1'b0};
    vecs[9]  = '{8'h3C, 4'd8,  4'd1, 4'd2, 8'h55, 8'h00, 1'b1};
    vecs[10] = '{8'h07, 4'd9,  4'd8, 4'd0, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{8'h02, 4'd10, 4'd1, 4'd7, 8'h00, 8'hF0, 1'b0};
    vecs[12] = '{8'h03, 4'd11, 4'd2, 4'd4, 8'h00, 8'h25, 1'b0};
    for (int i = 0; i < 16; i++) ref_regs[i] = 0;

    // Reset state.
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst out_result", out_result, 0);
    chk("rst out_rd", out_rd, 0);
    chk("rst out_illegal", out_illegal, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst in_ready", in_ready, 1);

    // Directed vector table.
    for (int i = 0; i < 13; i++)
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                vecs[i].exp_res, vecs[i].exp_ill, $sformatf("vec%0d", i));

    // Backpressure: result holds for 6 cycles and new requests are ignored.
    out_ready = 1'b0;
    in_opcode = 8'h06; in_rd = 4'd12; in_rs1 = 4'd0; in_rs2 = 4'd0; in_imm = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", lat, 3);
    in_opcode = 8'h06; in_rd = 4'd12; in_imm = 8'h11;
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d valid", c), out_valid, 1);
      chk($sformatf("bp hold%0d result", c), out_result, 8'h5A);
      chk($sformatf("bp hold%0d rd", c), out_rd, 12);
      chk($sformatf("bp hold%0d in_ready", c), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    chk("bp release result kept", out_result, 8'h5A);
    $display("instr bp LDI r12=5A held 6 cycles, res=%02h", out_result);
    ref_regs[12] = 8'h5A;
    run_model(8'h07, 4'd13, 4'd12, 4'd0, 8'h00, "bp_mov");

    // Reset during EX of LDI r1=0x77 aborts it and clears the register file.
    in_opcode = 8'h06; in_rd = 4'd1; in_rs1 = 4'd0; in_rs2 = 4'd0; in_imm = 8'h77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst out_result", out_result, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst in_ready", in_ready, 1);
    $display("instr midrst LDI r1=77 aborted");
    for (int i = 0; i < 16; i++) ref_regs[i] = 0;
    run_instr(8'h07, 4'd2, 4'd1, 4'd0, 8'h00, 8'h00, 1'b0, "midrst_mov");

    // Randomized instructions checked against the model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8) op = 8'(sel);
      else op = 8'($urandom_range(8, 255));
      run_model(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
